bsr_block_scheduler: RTL and testbench
======================================

# bsr_block_scheduler

Walks a BSR-encoded sparse weight matrix (row_ptr, col_idx, block payload memories) and issues each non-zero 8×8 INT8 block, tagged with its block row/column, to the sparse systolic array's block-input port. It is the initiator side of the array's valid_in/ready block handshake. It sits between the weight SRAMs and the array, under control of the layer sequencer (start/done).

## Interface
- DATA_WIDTH, 8, bits per weight element
- BLOCK_H, 8, block rows
- BLOCK_W, 8, block columns
- IDX_WIDTH, 16, width of block row/column indices and row count
- PTR_WIDTH, 16, width of row_ptr values and block/col_idx addresses

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begin a layer; ignored unless idle
- num_block_rows  in  IDX_WIDTH  block rows in the layer, sampled with start
- rp_rd_en / rp_addr  out  1 / IDX_WIDTH  row_ptr read; data returns next cycle
- rp_rdata  in  PTR_WIDTH  row_ptr[rp_addr], valid one cycle after rp_rd_en
- ci_rd_en / ci_addr  out  1 / PTR_WIDTH  col_idx read, 1-cycle latency
- ci_rdata  in  IDX_WIDTH  col_idx[ci_addr]
- blk_rd_en / blk_addr  out  1 / PTR_WIDTH  block payload read, 1-cycle latency, same address as col_idx
- blk_rdata  in  BLOCK_H*BLOCK_W*DATA_WIDTH  row-major block, element e at bits [e*8 +: 8]
- valid_out  out  1  block presented to array
- block_data  out  DATA_WIDTH × [0:63]  unpacked block, element e = row e/8, col e%8
- block_row / block_col  out  IDX_WIDTH each  tags of presented block
- ready  in  1  array idle and able to accept
- busy  out  1  layer in progress
- done  out  1  one-cycle pulse at layer completion
- err_ptr  out  1  sticky: non-monotonic row_ptr seen; cleared by start or rst
- blocks_issued / rows_skipped / stall_cycles  out  32 each  performance counters

## Operation
- States: IDLE, RP_FIRST, RP_NEXT, ROW, FETCH, CAP, ISSUE, HOLD, DONE.
- IDLE: start=1 latches num_block_rows, clears err_ptr, sets row r=0, busy=1. If num_block_rows==0, go to DONE. Otherwise, go to RP_FIRST.
- RP_FIRST: read row_ptr[0].
- RP_NEXT: on the first row only, capture rp_rdata as ptr_start. Read row_ptr[r+1].
- ROW: capture ptr_end=rp_rdata, k=ptr_start.
  - ptr_end>ptr_start: go to FETCH.
  - ptr_end==ptr_start: empty row; rows_skipped++; advance row.
  - ptr_end<ptr_start: set err_ptr; treat row as empty; advance row.
- FETCH: read col_idx[k] and block[k] together.
- CAP: register blk_rdata into block_data, ci_rdata into block_col, r into block_row.
- ISSUE: valid_out=1 until ready=1 (acceptance edge). Each cycle with ready=0 increments stall_cycles.
- HOLD: valid_out stays 1 with all tags/data unchanged for exactly one cycle after acceptance (the array latches block_data one cycle after accepting). blocks_issued++. Then:
  - k+1<ptr_end: k++, go to FETCH.
  - Otherwise: advance row.
- Advance row: ptr_start=ptr_end (row_ptr[r+1] never re-read), r++.
  - r==num_block_rows: go to DONE.
  - Otherwise: go to RP_NEXT.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- Outputs change only in CAP. valid_out is 0 in every state except ISSUE/HOLD.
- All counters wrap at 2^32. Counters are cleared by rst only, not by start.

## Timing
- Reset values: valid_out=0, busy=0, done=0, err_ptr=0, all rd_en=0, all addresses 0, block_data all 0, block_row=0, block_col=0, counters 0.
- rst mid-layer: on the next edge the block is in IDLE, valid_out=0, and no done pulse is issued.
- Start sampled in cycle 0 (row 0 non-empty):
  - RP_FIRST c1, RP_NEXT c2, ROW c3, FETCH c4, CAP c5.
  - valid_out first high in c6.
- Back-to-back blocks in the same row: next valid_out 3 cycles after the HOLD cycle (FETCH, CAP, ISSUE).
- Empty row costs 2 cycles (RP_NEXT, ROW).
- done pulses in the cycle after the last HOLD (or last ROW). busy falls in that same cycle.
- num_block_rows==0: done in c1.
- start while busy is ignored.
- start in the DONE cycle is ignored; accepted from the next cycle.
- ready=1 outside ISSUE has no effect.

## Configuration
- BSR_SCHED_PERF_EN defined: blocks_issued, rows_skipped and stall_cycles count as specified.
- BSR_SCHED_PERF_EN not defined: the three counter ports still exist but are tied to 0, and no counter registers are built.
- Functional behaviour is identical in both builds.

## Test plan
- num_block_rows=2, row_ptr={0,2,3}, col_idx={1,4,0}, ready=1 always:
  - three blocks issued, tags (0,1), (0,4), (1,0), in that order;
  - first valid_out 6 cycles after start, each valid held 2 cycles;
  - done once, blocks_issued=3.
- Same layer, ready held low 10 cycles at each ISSUE: data/tags stable throughout, stall_cycles=30, order unchanged.
- row_ptr={0,0,0,1}, num_block_rows=3: only block (2,col_idx[0]) issued; rows_skipped=2.
- num_block_rows=0: done pulses in cycle 1, valid_out never asserts, no memory reads.
- row_ptr={0,3,1} (non-monotonic), num_block_rows=2: row 0 issues 3 blocks; row 1 issues nothing; err_ptr=1 and stays 1 until the next start.
- rst asserted during HOLD of the second block: valid_out=0 and busy=0 next cycle, no done pulse; a new start replays the layer from row 0.

Source files
------------

// File: rtl/bsr_block_scheduler.sv
// Block-sparse row walker: reads row_ptr/col_idx/block memories and issues each non-zero
// block to the systolic array over a valid_out/ready handshake. Define BSR_SCHED_PERF_EN for perf counters.
module bsr_block_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_H    = 8,
  parameter int BLOCK_W    = 8,
  parameter int IDX_WIDTH  = 16,
  parameter int PTR_WIDTH  = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [IDX_WIDTH-1:0]                  num_block_rows,
  output logic                                  rp_rd_en,
  output logic [IDX_WIDTH-1:0]                  rp_addr,
  input  logic [PTR_WIDTH-1:0]                  rp_rdata,
  output logic                                  ci_rd_en,
  output logic [PTR_WIDTH-1:0]                  ci_addr,
  input  logic [IDX_WIDTH-1:0]                  ci_rdata,
  output logic                                  blk_rd_en,
  output logic [PTR_WIDTH-1:0]                  blk_addr,
  input  logic [BLOCK_H*BLOCK_W*DATA_WIDTH-1:0] blk_rdata,
  output logic                                  valid_out,
  output logic [DATA_WIDTH-1:0]                 block_data [0:BLOCK_H*BLOCK_W-1],
  output logic [IDX_WIDTH-1:0]                  block_row,
  output logic [IDX_WIDTH-1:0]                  block_col,
  input  logic                                  ready,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err_ptr,
  output logic [31:0]                           blocks_issued,
  output logic [31:0]                           rows_skipped,
  output logic [31:0]                           stall_cycles
);
  // Handshake: a block is accepted on the rising edge where valid_out && ready in ISSUE;
  // valid_out then stays high, with data and tags frozen, for the one HOLD cycle.
  localparam int NELEM = BLOCK_H * BLOCK_W;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_RP_FIRST = 4'd1;
  localparam logic [3:0] S_RP_NEXT  = 4'd2;
  localparam logic [3:0] S_ROW      = 4'd3;
  localparam logic [3:0] S_FETCH    = 4'd4;
  localparam logic [3:0] S_CAP      = 4'd5;
  localparam logic [3:0] S_ISSUE    = 4'd6;
  localparam logic [3:0] S_HOLD     = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  logic [3:0]           state;
  logic [IDX_WIDTH-1:0] n_rows;
  logic [IDX_WIDTH-1:0] r;
  logic [IDX_WIDTH-1:0] r_inc;
  logic [PTR_WIDTH-1:0] ptr_start;
  logic [PTR_WIDTH-1:0] ptr_end;
  logic [PTR_WIDTH-1:0] k;
  logic [PTR_WIDTH-1:0] k_inc;

  assign r_inc = r + 1'b1;
  assign k_inc = k + 1'b1;

  assign rp_rd_en  = (state == S_RP_FIRST) || (state == S_RP_NEXT);
  assign rp_addr   = (state == S_RP_NEXT) ? r_inc : '0;
  assign ci_rd_en  = (state == S_FETCH);
  assign ci_addr   = (state == S_FETCH) ? k : '0;
  assign blk_rd_en = (state == S_FETCH);
  assign blk_addr  = (state == S_FETCH) ? k : '0;
  assign valid_out = (state == S_ISSUE) || (state == S_HOLD);
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      n_rows    <= '0;
      r         <= '0;
      ptr_start <= '0;
      ptr_end   <= '0;
      k         <= '0;
      err_ptr   <= 1'b0;
      block_row <= '0;
      block_col <= '0;
      for (int e = 0; e < NELEM; e++) block_data[e] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n_rows  <= num_block_rows;
            err_ptr <= 1'b0;
            r       <= '0;
            state   <= (num_block_rows == '0) ? S_DONE : S_RP_FIRST;
          end
        end
        S_RP_FIRST: state <= S_RP_NEXT;
        S_RP_NEXT: begin
          // Later rows inherit ptr_start from the previous row's end pointer.
          if (r == '0) ptr_start <= rp_rdata;
          state <= S_ROW;
        end
        S_ROW: begin
          ptr_end <= rp_rdata;
          k       <= ptr_start;
          if (rp_rdata > ptr_start) begin
            state <= S_FETCH;
          end else begin
            if (rp_rdata < ptr_start) err_ptr <= 1'b1;
            ptr_start <= rp_rdata;
            r         <= r_inc;
            state     <= (r_inc == n_rows) ? S_DONE : S_RP_NEXT;
          end
        end
        S_FETCH: state <= S_CAP;
        S_CAP: begin
          for (int e = 0; e < NELEM; e++)
            block_data[e] <= blk_rdata[e*DATA_WIDTH +: DATA_WIDTH];
          block_col <= ci_rdata;
          block_row <= r;
          state     <= S_ISSUE;
        end
        S_ISSUE: if (ready) state <= S_HOLD;
        S_HOLD: begin
          if (k_inc < ptr_end) begin
            k     <= k_inc;
            state <= S_FETCH;
          end else begin
            ptr_start <= ptr_end;
            r         <= r_inc;
            state     <= (r_inc == n_rows) ? S_DONE : S_RP_NEXT;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BSR_SCHED_PERF_EN
  logic [31:0] blk_cnt;
  logic [31:0] skip_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt   <= '0;
      skip_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == S_HOLD) blk_cnt <= blk_cnt + 32'd1;
      if (state == S_ROW && rp_rdata == ptr_start) skip_cnt <= skip_cnt + 32'd1;
      if (state == S_ISSUE && !ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign blocks_issued = blk_cnt;
  assign rows_skipped  = skip_cnt;
  assign stall_cycles  = stall_cnt;
`else
  assign blocks_issued = '0;
  assign rows_skipped  = '0;
  assign stall_cycles  = '0;
`endif

endmodule

// File: tb/tb_bsr_block_scheduler.sv
// Directed bench for bsr_block_scheduler: memory models, ready driver, and a scoreboard
// monitor that checks every presented block against an expected queue.
module tb_bsr_block_scheduler;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  num_block_rows = '0;
  logic         rp_rd_en, ci_rd_en, blk_rd_en;
  logic [15:0]  rp_addr, ci_addr, blk_addr;
  logic [15:0]  rp_rdata = '0;
  logic [15:0]  ci_rdata = '0;
  logic [511:0] blk_rdata = '0;
  logic         valid_out;
  logic [7:0]   block_data [0:63];
  logic [15:0]  block_row, block_col;
  logic         ready = 1'b1;
  logic         busy, done, err_ptr;
  logic [31:0]  blocks_issued, rows_skipped, stall_cycles;

  bsr_block_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .num_block_rows(num_block_rows),
    .rp_rd_en(rp_rd_en), .rp_addr(rp_addr), .rp_rdata(rp_rdata),
    .ci_rd_en(ci_rd_en), .ci_addr(ci_addr), .ci_rdata(ci_rdata),
    .blk_rd_en(blk_rd_en), .blk_addr(blk_addr), .blk_rdata(blk_rdata),
    .valid_out(valid_out), .block_data(block_data),
    .block_row(block_row), .block_col(block_col), .ready(ready),
    .busy(busy), .done(done), .err_ptr(err_ptr),
    .blocks_issued(blocks_issued), .rows_skipped(rows_skipped), .stall_cycles(stall_cycles)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory models, 1-cycle read latency
  logic [15:0] rp_mem [0:7];
  logic [15:0] ci_mem [0:7];

  function automatic logic [511:0] pat(input logic [15:0] a);
    logic [511:0] v;
    for (int e = 0; e < 64; e++) v[e*8 +: 8] = a[7:0] * 8'd37 + 8'(e);
    return v;
  endfunction

  always @(posedge clk) begin
    if (rp_rd_en)  rp_rdata  <= rp_mem[rp_addr[2:0]];
    if (ci_rd_en)  ci_rdata  <= ci_mem[ci_addr[2:0]];
    if (blk_rd_en) blk_rdata <= pat(blk_addr);
  end

  // scoreboard state
  int n_checks = 0;
  int n_fails  = 0;
  logic [47:0] exp_q[$];
  logic [47:0] cur = '0;
  int t0 = 0;
  int first_lat = -1;
  int done_lat = -1;
  int done_cnt = 0;
  int rd_cnt = 0;
  int vlen = 0;
  int exp_len = 2;
  logic prev_v = 1'b0;
  logic stall_mode = 1'b0;
  int wcnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_block(input string name);
    logic [511:0] act;
    for (int e = 0; e < 64; e++) act[e*8 +: 8] = block_data[e];
    check({name, "_row"}, 64'(block_row), 64'(cur[47:32]));
    check({name, "_col"}, 64'(block_col), 64'(cur[31:16]));
    n_checks++;
    if (act !== pat(cur[15:0])) begin
      n_fails++;
      $display("FAIL %s_data: got %0h expected %0h", name, act, pat(cur[15:0]));
    end
  endtask

  function automatic logic [63:0] perf(input int v);
`ifdef BSR_SCHED_PERF_EN
    return 64'(v);
`else
    return 64'(v - v);
`endif
  endfunction

  // ready driver: either always ready, or hold ready low for 10 cycles of each ISSUE
  always @(negedge clk) begin
    if (!stall_mode) ready = 1'b1;
    else if (!valid_out) begin ready = 1'b0; wcnt = 0; end
    else if (wcnt < 10) begin ready = 1'b0; wcnt++; end
    else ready = 1'b1;
  end

  // monitor: pops one expectation per presented block, then checks it stays stable
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
      vlen = 0;
    end else begin
      if (valid_out && !prev_v) begin
        if (first_lat < 0) first_lat = cyc - t0;
        if (exp_q.size() == 0) begin
          check("unexpected_block", 64'(block_row), 64'hffff);
        end else begin
          cur = exp_q.pop_front();
          check_block("block");
        end
        vlen = 1;
      end else if (valid_out) begin
        vlen++;
        check_block("stable");
      end else if (prev_v) begin
        check("valid_len", 64'(vlen), 64'(exp_len));
      end
      prev_v = valid_out;
      if (done) begin
        done_cnt++;
        done_lat = cyc - t0;
        check("busy_at_done", 64'(busy), 64'd0);
      end
      if (rp_rd_en || ci_rd_en || blk_rd_en) rd_cnt++;
    end
  end

  // driver tasks
  task automatic push(input logic [15:0] row, input logic [15:0] col, input logic [15:0] addr);
    exp_q.push_back({row, col, addr});
  endtask

  task automatic start_layer(input logic [15:0] n);
    @(negedge clk);
    t0 = cyc;
    first_lat = -1;
    rd_cnt = 0;
    num_block_rows = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_layer(input string name, input logic [15:0] n,
                           input int exp_first, input int exp_done);
    int d0;
    d0 = done_cnt;
    start_layer(n);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
      @(negedge clk);
      #1;
    end
    check({name, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    check({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_first_valid_lat"}, 64'(first_lat), 64'(exp_first));
    check({name, "_done_lat"}, 64'(done_lat), 64'(exp_done));
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 8; i++) begin rp_mem[i] = '0; ci_mem[i] = '0; end
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err_ptr), 64'd0);
    check("rst_rd_en", 64'({rp_rd_en, ci_rd_en, blk_rd_en}), 64'd0);
    check("rst_addr", 64'({rp_addr, ci_addr, blk_addr}), 64'd0);
    check("rst_tags", 64'({block_row, block_col}), 64'd0);
    check("rst_data0", 64'({block_data[0], block_data[63]}), 64'd0);
    check("rst_counters", 64'(blocks_issued | rows_skipped | stall_cycles), 64'd0);
    rst = 1'b0;

    // two rows, three blocks, ready always high
    rp_mem[0] = 16'd0; rp_mem[1] = 16'd2; rp_mem[2] = 16'd3;
    ci_mem[0] = 16'd1; ci_mem[1] = 16'd4; ci_mem[2] = 16'd0;
    push(16'd0, 16'd1, 16'd0); push(16'd0, 16'd4, 16'd1); push(16'd1, 16'd0, 16'd2);
    exp_len = 2;
    run_layer("basic", 16'd2, 6, 18);
    check("basic_blocks_issued", 64'(blocks_issued), perf(3));

    // same layer with 10 stall cycles at every ISSUE
    stall_mode = 1'b1;
    exp_len = 12;
    push(16'd0, 16'd1, 16'd0); push(16'd0, 16'd4, 16'd1); push(16'd1, 16'd0, 16'd2);
    run_layer("stall", 16'd2, 6, 48);
    check("stall_cycles", 64'(stall_cycles), perf(30));
    check("stall_blocks_issued", 64'(blocks_issued), perf(6));
    stall_mode = 1'b0;
    exp_len = 2;

    // two empty rows ahead of a single block
    rp_mem[0] = 16'd0; rp_mem[1] = 16'd0; rp_mem[2] = 16'd0; rp_mem[3] = 16'd1;
    ci_mem[0] = 16'd7;
    push(16'd2, 16'd7, 16'd0);
    run_layer("skip", 16'd3, 10, 12);
    check("rows_skipped", 64'(rows_skipped), perf(2));
    check("skip_blocks_issued", 64'(blocks_issued), perf(7));

    // empty layer: done in cycle 1, no reads, no blocks
    run_layer("zero", 16'd0, -1, 1);
    check("zero_reads", 64'(rd_cnt), 64'd0);

    // non-monotonic row_ptr
    rp_mem[0] = 16'd0; rp_mem[1] = 16'd3; rp_mem[2] = 16'd1;
    ci_mem[0] = 16'd2; ci_mem[1] = 16'd5; ci_mem[2] = 16'd6;
    push(16'd0, 16'd2, 16'd0); push(16'd0, 16'd5, 16'd1); push(16'd0, 16'd6, 16'd2);
    run_layer("badptr", 16'd2, 6, 18);
    check("err_ptr_set", 64'(err_ptr), 64'd1);
    repeat (5) @(negedge clk);
    check("err_ptr_sticky", 64'(err_ptr), 64'd1);

    // reset during HOLD of the second block, then replay the layer
    rp_mem[0] = 16'd0; rp_mem[1] = 16'd2; rp_mem[2] = 16'd3;
    ci_mem[0] = 16'd1; ci_mem[1] = 16'd4; ci_mem[2] = 16'd0;
    push(16'd0, 16'd1, 16'd0); push(16'd0, 16'd4, 16'd1);
    d0 = done_cnt;
    start_layer(16'd2);
    check("err_ptr_cleared", 64'(err_ptr), 64'd0);
    repeat (10) @(negedge clk);
    check("hold_valid", 64'(valid_out), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_valid", 64'(valid_out), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_queue_empty", 64'(exp_q.size()), 64'd0);
    check("abort_counters", 64'(blocks_issued), 64'd0);
    push(16'd0, 16'd1, 16'd0); push(16'd0, 16'd4, 16'd1); push(16'd1, 16'd0, 16'd2);
    run_layer("replay", 16'd2, 6, 18);
    check("replay_blocks_issued", 64'(blocks_issued), perf(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
